// File: rtl/rc4_key_search.sv
// rc4_key_search: brute-force RC4 key search over the inclusive range key_lo..key_hi.
// For each candidate key the S box in the external S RAM is initialised and scheduled
// (KSA), then MSG_LEN bytes of ciphertext are decrypted into the plaintext RAM (PRGA).
// Every RAM/ROM read returns data one cycle after its address is presented.
// Optional feature: define RC4_KS_ASCII_CHECK_EN to accept only keys whose plaintext
// consists of lowercase letters and spaces, aborting a candidate at its first bad byte.
// Without it every byte passes, so key_lo is reported after one full decrypt.
module rc4_key_search #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key_lo,
    input  logic [8*KEY_BYTES-1:0] key_hi,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rdata,
    output logic [7:0]             e_addr,
    input  logic [7:0]             e_rdata,
    output logic [7:0]             d_addr,
    output logic [7:0]             d_wdata,
    output logic                   d_wren,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [8*KEY_BYTES-1:0] key_out
);
    localparam int         KW      = 8 * KEY_BYTES;
    localparam logic [7:0] LAST_K  = 8'(MSG_LEN - 1);
    localparam logic [2:0] LAST_KB = 3'(KEY_BYTES - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] KSA    = 3'd2;
    localparam logic [2:0] PRGA   = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] NEXT   = 3'd5;
    localparam logic [2:0] FINISH = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [2:0]    step_q, step_d;     // micro-step inside one KSA/PRGA iteration
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [7:0]    k_q, k_d;           // message byte index
    logic [2:0]    kb_q, kb_d;         // i mod KEY_BYTES, tracked without a divider
    logic [7:0]    si_q, si_d;         // S[i] captured before the swap
    logic [7:0]    sj_q, sj_d;         // S[j] captured before the swap
    logic          byte_ok_q, byte_ok_d;
    logic          found_q, found_d;
    logic [KW-1:0] key_q, key_d;
    logic [KW-1:0] key_hi_q, key_hi_d; // range end captured at start

    logic [7:0]    key_byte;
    logic [7:0]    j_sum;
    logic [7:0]    i_inc;
    logic [7:0]    pt_byte;

    assign i_inc   = i_q + 8'd1;
    assign pt_byte = s_rdata ^ e_rdata;

    assign busy    = (state_q != IDLE) && (state_q != FINISH);
    assign done    = (state_q == FINISH);
    assign found   = found_q;
    assign key_out = key_q;

    // Select key byte (i mod KEY_BYTES), byte 0 being the most significant.
    always_comb begin
        key_byte = 8'd0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kb_q == 3'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    // Next-state and memory-port decode for the search FSM.
    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d   = state_q;
        step_d    = step_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        kb_d      = kb_q;
        si_d      = si_q;
        sj_d      = sj_q;
        byte_ok_d = byte_ok_q;
        found_d   = found_q;
        key_d     = key_q;
        key_hi_d  = key_hi_q;
        j_sum     = 8'd0;
        s_addr    = 8'd0;
        s_wdata   = 8'd0;
        s_wren    = 1'b0;
        e_addr    = 8'd0;
        d_addr    = 8'd0;
        d_wdata   = 8'd0;
        d_wren    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d    = key_lo;
                    key_hi_d = key_hi;
                    found_d  = 1'b0;
                    i_d      = 8'd0;
                    j_d      = 8'd0;
                    k_d      = 8'd0;
                    kb_d     = 3'd0;
                    step_d   = 3'd0;
                    state_d  = (key_lo > key_hi) ? FINISH : INIT;
                end
            end

            INIT: begin
                s_addr  = i_q;
                s_wdata = i_q;
                s_wren  = 1'b1;
                i_d     = i_inc;
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    kb_d    = 3'd0;
                    step_d  = 3'd0;
                    state_d = KSA;
                end
            end

            KSA: begin
                case (step_q)
                    3'd0: begin
                        s_addr = i_q;
                        step_d = 3'd1;
                    end
                    3'd1: begin
                        si_d   = s_rdata;
                        j_sum  = j_q + s_rdata + key_byte;
                        j_d    = j_sum;
                        s_addr = j_sum;
                        step_d = 3'd2;
                    end
                    3'd2: begin
                        s_addr  = i_q;
                        s_wdata = s_rdata;
                        s_wren  = 1'b1;
                        step_d  = 3'd3;
                    end
                    default: begin
                        s_addr  = j_q;
                        s_wdata = si_q;
                        s_wren  = 1'b1;
                        i_d     = i_inc;
                        kb_d    = (kb_q == LAST_KB) ? 3'd0 : kb_q + 3'd1;
                        step_d  = 3'd0;
                        if (i_q == 8'hFF) begin
                            j_d     = 8'd0;
                            k_d     = 8'd0;
                            state_d = PRGA;
                        end
                    end
                endcase
            end

            PRGA: begin
                case (step_q)
                    3'd0: begin
                        i_d    = i_inc;
                        s_addr = i_inc;
                        step_d = 3'd1;
                    end
                    3'd1: begin
                        si_d   = s_rdata;
                        j_sum  = j_q + s_rdata;
                        j_d    = j_sum;
                        s_addr = j_sum;
                        step_d = 3'd2;
                    end
                    3'd2: begin
                        sj_d    = s_rdata;
                        s_addr  = i_q;
                        s_wdata = s_rdata;
                        s_wren  = 1'b1;
                        step_d  = 3'd3;
                    end
                    3'd3: begin
                        s_addr  = j_q;
                        s_wdata = si_q;
                        s_wren  = 1'b1;
                        step_d  = 3'd4;
                    end
                    3'd4: begin
                        // Swap leaves S[i]+S[j] unchanged, so the saved values index f.
                        s_addr = si_q + sj_q;
                        e_addr = k_q;
                        step_d = 3'd5;
                    end
                    default: begin
                        d_addr  = k_q;
                        d_wdata = pt_byte;
                        d_wren  = 1'b1;
`ifdef RC4_KS_ASCII_CHECK_EN
                        byte_ok_d = ((pt_byte >= 8'h61) && (pt_byte <= 8'h7A)) ||
                                    (pt_byte == 8'h20);
`else
                        byte_ok_d = 1'b1;
`endif
                        step_d  = 3'd0;
                        state_d = CHECK;
                    end
                endcase
            end

            CHECK: begin
                if (!byte_ok_q) begin
                    state_d = NEXT;
                end else if (k_q == LAST_K) begin
                    found_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = PRGA;
                end
            end

            NEXT: begin
                if ((key_q == key_hi_q) || (key_q == '1)) begin
                    state_d = FINISH;
                end else begin
                    key_d   = key_q + KW'(1);
                    i_d     = 8'd0;
                    state_d = INIT;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset cycle must not commit a write that was already being driven.
        if (reset) begin
            s_addr  = 8'd0;
            s_wdata = 8'd0;
            s_wren  = 1'b0;
            e_addr  = 8'd0;
            d_addr  = 8'd0;
            d_wdata = 8'd0;
            d_wren  = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= 8'd0;
            kb_q      <= 3'd0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            byte_ok_q <= 1'b0;
            found_q   <= 1'b0;
            key_q     <= '0;
            key_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            kb_q      <= kb_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            byte_ok_q <= byte_ok_d;
            found_q   <= found_d;
            key_q     <= key_d;
            key_hi_q  <= key_hi_d;
        end
    end

endmodule

// File: tb/tb_rc4_key_search.sv
// Bench for rc4_key_search. Default build: KEY_BYTES=3, MSG_LEN=9 ("Key"/"Plaintext").
// With RC4_KS_ASCII_CHECK_EN: KEY_BYTES=4, MSG_LEN=5 ("Wiki"/"pedia").
// Expectations are queued at start; a monitor checks them on every done pulse.
module tb_rc4_key_search;
`ifdef RC4_KS_ASCII_CHECK_EN
    localparam int KB = 4;
    localparam int ML = 5;
    localparam logic [8*ML-1:0] PT_C     = 40'h7065646961;
    localparam logic [8*ML-1:0] CT_C     = 40'h1021BF0420;
    localparam logic [8*KB-1:0] KEY_GOOD = 32'h57696B69;
    localparam logic [8*KB-1:0] KEY_BAD  = 32'h57696B68;
    localparam logic [8*KB-1:0] RNG_LO   = 32'h57696B66;
    localparam logic [8*KB-1:0] RNG_HI   = 32'h57696B69;
    localparam logic [8*KB-1:0] RNG_EXP  = 32'h57696B69;
`else
    localparam int KB = 3;
    localparam int ML = 9;
    localparam logic [8*ML-1:0] PT_C     = 72'h506C61696E74657874;
    localparam logic [8*ML-1:0] CT_C     = 72'hBBF316E8D940AF0AD3;
    localparam logic [8*KB-1:0] KEY_GOOD = 24'h4B6579;
    localparam logic [8*KB-1:0] RNG_LO   = 24'h4B6579;
    localparam logic [8*KB-1:0] RNG_HI   = 24'h4B657C;
    localparam logic [8*KB-1:0] RNG_EXP  = 24'h4B6579;
`endif
    localparam int KW     = 8 * KB;
    localparam int BUDGET = 12000;

    typedef struct {
        logic          found;
        logic [KW-1:0] key;
        logic          chk_pt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] key_lo = '0;
    logic [KW-1:0] key_hi = '0;
    logic [7:0]    s_addr, s_wdata, s_rdata, e_addr, e_rdata, d_addr, d_wdata;
    logic          s_wren, d_wren, busy, done, found;
    logic [KW-1:0] key_out;

    logic [7:0]    s_mem [256];
    logic [7:0]    e_mem [256];
    logic [7:0]    d_mem [256];
    logic [8*ML-1:0] pt_v;
    exp_t          exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    logic          wren_seen = 1'b0;

    rc4_key_search #(.KEY_BYTES(KB), .MSG_LEN(ML)) dut (
        .clk(clk), .reset(reset), .start(start), .key_lo(key_lo), .key_hi(key_hi),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
        .e_addr(e_addr), .e_rdata(e_rdata),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
        .busy(busy), .done(done), .found(found), .key_out(key_out)
    );

    always #5 clk = ~clk;

    // S RAM and E ROM with one-cycle read latency.
    always @(posedge clk) begin
        s_rdata <= s_mem[s_addr];
        if (s_wren) s_mem[s_addr] <= s_wdata;
        e_rdata <= e_mem[e_addr];
    end

    // D RAM; only read by the bench at negedges.
    always @(posedge clk) begin
        if (d_wren) d_mem[d_addr] = d_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    // Monitor: compare each done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (s_wren || d_wren) wren_seen = 1'b1;
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", busy, 0);
            check("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("found", found, e.found);
                check("key_out", key_out, e.key);
                if (e.chk_pt) begin
                    for (int b = 0; b < ML; b++)
                        check($sformatf("d_byte%0d", b), d_mem[b], pt_v[8*(ML-1-b) +: 8]);
                end
            end
        end
    end

    task automatic run_search(input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                              input logic exp_found, input logic [KW-1:0] exp_key,
                              input logic chk_pt, input int dup_at, output int cyc);
        exp_t e;
        int   n0;
        e.found = exp_found;
        e.key = exp_key;
        e.chk_pt = chk_pt;
        for (int a = 0; a < 256; a++) d_mem[a] = 8'h00;
        @(posedge clk);
        #1;
        n0 = done_cnt;
        wren_seen = 1'b0;
        exp_q.push_back(e);
        key_lo = lo;
        key_hi = hi;
        start = 1'b1;
        cyc = 0;
        while (done_cnt == n0 && cyc < BUDGET) begin
            @(posedge clk);
            #1;
            start = (cyc == dup_at);
            if (cyc == dup_at) begin
                key_lo = '0;
                key_hi = '1;
            end
            cyc++;
        end
        start = 1'b0;
        check("search_completes", done_cnt != n0, 1);
        if (done_cnt == n0) exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("found_hold", found, exp_found);
        check("key_hold", key_out, exp_key);
        check("single_done", done_cnt, n0 + 1);
    endtask

    initial begin
        logic [8*ML-1:0] ct_v;
        int cyc;
        pt_v = PT_C;
        ct_v = CT_C;
        for (int a = 0; a < 256; a++) begin
            s_mem[a] = 8'h00;
            e_mem[a] = 8'h00;
            d_mem[a] = 8'h00;
        end
        for (int b = 0; b < ML; b++) e_mem[b] = ct_v[8*(ML-1-b) +: 8];

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_key", key_out, 0);
        check("rst_s_wren", s_wren, 0);
        check("rst_d_wren", d_wren, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_e_addr", e_addr, 0);
        check("rst_d_addr", d_addr, 0);

        // Single known-good key.
        run_search(KEY_GOOD, KEY_GOOD, 1'b1, KEY_GOOD, 1'b1, -1, cyc);
        // Key range: first accepted key is reported.
        run_search(RNG_LO, RNG_HI, 1'b1, RNG_EXP, 1'b1, -1, cyc);
`ifdef RC4_KS_ASCII_CHECK_EN
        // Single rejected key.
        run_search(KEY_BAD, KEY_BAD, 1'b0, KEY_BAD, 1'b0, -1, cyc);
`endif
        // Empty range: immediate finish, no writes.
        run_search(KW'(5), KW'(3), 1'b0, KW'(5), 1'b0, -1, cyc);
        check("empty_range_latency", cyc <= 2, 1);
        check("empty_range_no_wren", wren_seen, 0);

        // Reset in the middle of KSA, then rerun.
        @(posedge clk);
        #1;
        key_lo = KEY_GOOD;
        key_hi = KEY_GOOD;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("busy_before_reset", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_s_wren", s_wren, 0);
        check("abort_d_wren", d_wren, 0);
        check("abort_found", found, 0);
        check("abort_key", key_out, 0);
        check("abort_s_addr", s_addr, 0);
        run_search(KEY_GOOD, KEY_GOOD, 1'b1, KEY_GOOD, 1'b1, -1, cyc);

        // Second start while busy must be ignored.
        run_search(KEY_GOOD, KEY_GOOD, 1'b1, KEY_GOOD, 1'b1, 20, cyc);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rc4_key_search.md
RC4_KEY_SEARCH -- requirements
Module: rc4_key_search

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- KEY_BYTES, 3, secret key length in bytes (1..8).
- MSG_LEN, 32, number of ciphertext/plaintext bytes (1..256).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a search.
- key_lo  in  8*KEY_BYTES  first key to try.
- key_hi  in  8*KEY_BYTES  last key to try, inclusive.
- s_addr / s_wdata / s_wren  out  8/8/1  S RAM port.
- s_rdata  in  8  S RAM read data.
- e_addr  out  8  ciphertext ROM address.
- e_rdata  in  8  ciphertext ROM data.
- d_addr / d_wdata / d_wren  out  8/8/1  plaintext RAM port.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse at search end.
- found  out  1  held high after a key succeeds.
- key_out  out  8*KEY_BYTES  current or winning key.

Function
REQ-003 All RAM/ROM ports SHALL have 1-cycle read latency: an address presented in cycle n returns data in cycle n+1; a write commits at the clock edge.
REQ-004 The FSM SHALL use states IDLE, INIT, KSA, PRGA, CHECK, NEXT, FINISH.
REQ-005 In IDLE, start=1 SHALL load key_out<=key_lo, clear found, set busy, and enter INIT; start while busy SHALL be ignored.
REQ-006 If key_lo > key_hi at start, the block SHALL go directly to FINISH: no RAM writes, found=0.
REQ-007 INIT SHALL write S[i]=i for i=0..255, one write per cycle (exactly 256 cycles), then enter KSA with i=0 and j=0.
REQ-008 In KSA, for each i=0..255 the block SHALL:
- compute j=(j+S[i]+key_out byte[i mod KEY_BYTES]) mod 256, with byte 0 the most significant byte;
- swap S[i] and S[j], including when i==j.
REQ-009 In PRGA, for k=0..MSG_LEN-1, starting from i=j=0, the block SHALL:
- compute i=i+1 and j=j+S[i] (mod 256), then swap;
- compute f=S[(S[i]+S[j]) mod 256];
- write D[k]=f XOR E[k].
REQ-010 All index arithmetic SHALL be 8-bit and wrap modulo 256.
REQ-011 A key SHALL succeed when all MSG_LEN bytes pass CHECK (see REQ-016). On success: found<=1, key_out holds the key, enter FINISH.
REQ-012 A rejected key SHALL enter NEXT:
- if key_out==key_hi, go to FINISH with found=0;
- otherwise key_out<=key_out+1 and return to INIT.
- key_out SHALL NOT wrap past the all-ones value.
REQ-013 FINISH SHALL pulse done for exactly one cycle, clear busy in that same cycle, and return to IDLE. found and key_out SHALL hold until the next start or reset.
REQ-014 s_wren and d_wren SHALL be 0 in every state other than INIT, KSA, and PRGA.

Reset
REQ-015 reset=1 at any clock edge, including mid-search, SHALL force IDLE on the next cycle:
- busy=0, done=0, found=0, key_out=0;
- s_wren=0, d_wren=0, and all addresses 0.
- No partial write SHALL occur in the reset cycle.

Configuration
REQ-016 With macro RC4_KS_ASCII_CHECK_EN defined:
- CHECK SHALL reject a key as soon as a decrypted byte lies outside 8'h61..8'h7A and is not 8'h20;
- rejection SHALL abort PRGA early, and bytes already written to D remain.
Without the macro:
- every byte passes, so the first key tried (key_lo) is reported found after a full MSG_LEN decrypt.

Verification
REQ-017 Directed scenarios:
- Macro off, KEY_BYTES=3, MSG_LEN=9, key_lo=key_hi=24'h4B6579 ("Key"), E=BB F3 16 E8 D9 40 AF 0A D3 -> D="Plaintext", found=1, key_out=24'h4B6579, one done pulse.
- Macro on, KEY_BYTES=4, MSG_LEN=5, E=10 21 BF 04 20, key_lo=32'h57696B66, key_hi=32'h57696B69 -> found=1, key_out=32'h57696B69 ("Wiki"), D="pedia".
- Macro on, same E, key_lo=key_hi=32'h57696B68 -> done pulse, found=0, key_out=32'h57696B68.
- key_lo=5, key_hi=3, start -> done within 2 cycles, found=0, no s_wren or d_wren asserted.
- reset asserted for one cycle during KSA -> next cycle busy=0, s_wren=0; a later start reruns and produces the correct result.
- start pulsed again while busy -> ignored; the result matches a single-start run.
